// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// EX-stage operation codes the controller decodes into start/signed_div.
// Ports: none (package).
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_RUN    = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_t;

    // Operation codes decoded by the EX controller into start/signed_div.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU, returns {remainder, quotient}.
// Latency: WIDTH+1 cycles from accepted start to ready (2 cycles for divisor zero).
// Backpressure: holds the pipeline through busy; start is only sampled in IDLE.
// Ports: clk, rst (sync, active-high), start, signed_div, dividend, divisor,
//        annul (abort), busy, ready (1-cycle pulse), result {HI, LO}.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 annul,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t          state;
    logic [CW-1:0]       counter;
    logic [2*WIDTH:0]    pr;        // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
    logic [WIDTH-1:0]    dvs;       // divisor magnitude
    logic                sign_q;
    logic                sign_r;

    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [2*WIDTH:0]    sh;
    logic [WIDTH+1:0]    diff;
    logic [2*WIDTH:0]    pr_step;
    logic [WIDTH-1:0]    q_fix;
    logic [WIDTH-1:0]    r_fix;
    logic                last;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    always_comb begin
        a_mag   = (signed_div && dividend[WIDTH-1]) ? neg(dividend) : dividend;
        b_mag   = (signed_div && divisor[WIDTH-1])  ? neg(divisor)  : divisor;

        sh      = pr << 1;
        // One guard bit above the shifted upper half so the borrow is exact
        // even when the shifted partial remainder reaches 2^WIDTH.
        diff    = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, dvs};
        pr_step = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};

        q_fix   = sign_q ? neg(pr_step[WIDTH-1:0])       : pr_step[WIDTH-1:0];
        r_fix   = sign_r ? neg(pr_step[2*WIDTH-1:WIDTH]) : pr_step[2*WIDTH-1:WIDTH];
        last    = (counter == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            counter <= '0;
            pr      <= '0;
            dvs     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            result  <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        pr      <= {(WIDTH+1)'(0), a_mag};
                        dvs     <= b_mag;
                        sign_q  <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r  <= signed_div & dividend[WIDTH-1];
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= (divisor == '0) ? DIV_BYZERO : DIV_RUN;
                    end
                end
                DIV_BYZERO: begin
                    busy <= 1'b0;
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        result <= '0;
                        ready  <= 1'b1;
                        state  <= DIV_DONE;
                    end
                end
                DIV_RUN: begin
                    if (annul) begin
                        busy    <= 1'b0;
                        counter <= '0;
                        state   <= DIV_IDLE;
                    end else begin
                        pr      <= pr_step;
                        counter <= counter + CW'(1);
                        // Fix-up is folded into the final step so result is
                        // already valid in the DONE cycle alongside ready.
                        if (last) begin
                            busy   <= 1'b0;
                            ready  <= 1'b1;
                            result <= {r_fix, q_fix};
                            state  <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
